mem_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single SPI memory transaction engine inside tt_um_mem_toplevel between NUM_REQ requesters (crypto core, host command path, ...).
- Grants one requester at a time and forwards its command to the engine. Routes write/read byte streams between the owner and the engine, and holds ownership until the engine reports done.
- An inactivity watchdog aborts a hung transaction and flags an error to the owner.

---
 rtl/mem_req_arbiter_if.sv | 62 ++++++
 rtl/mem_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the memory
// request arbiter. "master" is the arbiter's view; "slave" is the view of
// the environment (requesters plus SPI transaction engine).
//
// Handshake rule used by every channel here: a transfer happens in a cycle
// where valid and ready are both high. A producer holds valid and its
// payload stable until that cycle. The exception is eng_rvalid, which has no
// ready and is consumed in the cycle it is asserted.
interface mem_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 24
);
    localparam int OW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    // requester side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*8-1:0]      req_len;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*8-1:0]      wdata;
    logic [NUM_REQ-1:0]        wvalid;
    logic [NUM_REQ-1:0]        wready;
    logic [7:0]                rdata;
    logic [NUM_REQ-1:0]        rvalid;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;

    // engine side
    logic                      cmd_valid;
    logic                      cmd_write;
    logic [ADDR_W-1:0]         cmd_addr;
    logic [7:0]                cmd_len;
    logic                      cmd_ready;
    logic [7:0]                eng_wdata;
    logic                      eng_wvalid;
    logic                      eng_wready;
    logic [7:0]                eng_rdata;
    logic                      eng_rvalid;
    logic                      eng_done;
    logic                      eng_abort;

    // status
    logic                      busy;
    logic [OW-1:0]             owner;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wdata, wvalid,
        output req_ready, wready, rdata, rvalid, done, err,
        output cmd_valid, cmd_write, cmd_addr, cmd_len, eng_wdata, eng_wvalid, eng_abort,
        input  cmd_ready, eng_wready, eng_rdata, eng_rvalid, eng_done,
        output busy, owner
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wdata, wvalid,
        input  req_ready, wready, rdata, rvalid, done, err,
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, eng_wdata, eng_wvalid, eng_abort,
        output cmd_ready, eng_wready, eng_rdata, eng_rvalid, eng_done,
        input  busy, owner
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI memory transaction engine
// between NUM_REQ requesters. The owner keeps the engine from command
// accept until eng_done; an inactivity watchdog aborts hung transfers.
// All data routing is combinational from the registered owner/state, so it
// adds no latency; the only registered decision is the grant itself.
module mem_req_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 24,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_req_arbiter_if.master    bus,
    output logic [1:0]           o_dbg_state
);
    localparam int          OW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_XFER  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t        r_state;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_last;
    logic [15:0]   r_wd;

    logic          w_found;
    logic [OW-1:0] w_pick;
    logic [OW-1:0] w_idx;
    int            w_sum;
    logic          w_own_wvalid;
    logic          w_data_beat;
    logic          w_wd_hit;

    // Round-robin search: first valid requester after the last grant, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = int'(r_last) + k;
            w_idx = OW'(w_sum % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Any data beat in XFER is activity that restarts the watchdog.
    always_comb begin
        w_own_wvalid = bus.wvalid[r_owner];
        w_data_beat  = (w_own_wvalid & bus.eng_wready) | bus.eng_rvalid;
        w_wd_hit     = (r_wd == WD_LAST);
    end

    // Grant FSM with watchdog; eng_done beats a simultaneous timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= OW'(NUM_REQ - 1);
            r_wd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        r_wd    <= '0;
                        r_state <= S_CMD;
                    end
                end
                S_CMD: begin
                    // eng_done here is a protocol error and deliberately ignored
                    if (bus.cmd_ready) begin
                        r_wd    <= '0;
                        r_state <= S_XFER;
                    end else if (w_wd_hit) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                S_XFER: begin
                    if (bus.eng_done) begin
                        r_state <= S_IDLE;
                    end else if (w_data_beat) begin
                        r_wd <= '0;
                    end else if (w_wd_hit) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                S_ABORT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Route command/data between the owner and the engine according to state.
    always_comb begin
        bus.req_ready  = '0;
        bus.wready     = '0;
        bus.rvalid     = '0;
        bus.done       = '0;
        bus.err        = '0;
        bus.rdata      = '0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.eng_wdata  = '0;
        bus.eng_wvalid = 1'b0;
        bus.eng_abort  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (OW'(i) == r_owner) begin
                case (r_state)
                    S_CMD: begin
                        bus.cmd_valid    = 1'b1;
                        bus.cmd_write    = bus.req_write[i];
                        bus.cmd_addr     = bus.req_addr[i*ADDR_W +: ADDR_W];
                        bus.cmd_len      = bus.req_len[i*8 +: 8];
                        bus.req_ready[i] = bus.cmd_ready;
                    end
                    S_XFER: begin
                        bus.eng_wdata    = bus.wdata[i*8 +: 8];
                        bus.eng_wvalid   = bus.wvalid[i];
                        bus.wready[i]    = bus.eng_wready;
                        bus.rdata        = bus.eng_rdata;
                        bus.rvalid[i]    = bus.eng_rvalid;
                        bus.done[i]      = bus.eng_done;
                    end
                    S_ABORT: begin
                        bus.eng_abort    = 1'b1;
                        bus.err[i]       = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status decodes of the registered state.
    always_comb begin
        bus.busy    = (r_state != S_IDLE);
        bus.owner   = r_owner;
        o_dbg_state = r_state;
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (NUM_REQ=2, TIMEOUT_CYC=8): a cycle
// table for a single read, then hand-written sequences for round-robin,
// write backpressure, watchdog abort, done/timeout tie and mid-transfer reset.
module tb_mem_req_arbiter;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  mem_req_arbiter_if #(.NUM_REQ(2), .ADDR_W(24)) bus ();

  mem_req_arbiter #(.NUM_REQ(2), .ADDR_W(24), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  rv;
    logic        cr;
    logic        erv;
    logic [7:0]  erd;
    logic        edn;
    logic        e_cv;
    logic [1:0]  e_rrdy;
    logic [1:0]  e_rval;
    logic [7:0]  e_rd;
    logic [1:0]  e_dn;
    logic        e_busy;
    logic [23:0] e_addr;
    logic [7:0]  e_len;
  } vec_t;

  vec_t vecs[10];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.wvalid     = '0;
    bus.wdata      = '0;
    bus.cmd_ready  = 1'b0;
    bus.eng_wready = 1'b0;
    bus.eng_rdata  = '0;
    bus.eng_rvalid = 1'b0;
    bus.eng_done   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 0);
    chk({tag, "_cmd_fields"}, {bus.cmd_write, bus.cmd_len, bus.cmd_addr[22:0]}, 0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_wready"}, 32'(bus.wready), 0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 0);
    chk({tag, "_done_err"}, {28'd0, bus.done, bus.err}, 0);
    chk({tag, "_eng_w"}, {23'd0, bus.eng_wvalid, bus.eng_wdata}, 0);
    chk({tag, "_abort"}, 32'(bus.eng_abort), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_owner"}, 32'(bus.owner), 0);
  endtask

  // Waits (bounded) until cmd_valid is seen; returns at posedge+2 of that cycle.
  task automatic wait_cmd(input string tag, output bit found);
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.cmd_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_cmd_timeout: got no cmd_valid expected cmd_valid within 6 cycles", tag);
    end
  endtask

  initial begin
    bit   found;
    int   exp_own;
    int   idx;
    logic [7:0] wb[2];
    logic [31:0] got;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clear_inputs();
    bus.req_write = 2'b10;
    bus.req_addr  = {24'h002000, 24'h001000};
    bus.req_len   = {8'd1, 8'd3};

    // ---------------- reset state
    do_reset();
    #1;
    chk_all_zero("rst");

    // ---------------- single read, cycle table
    //            rv     cr    erv   erd    edn   cv    rrdy   rval   rd     dn     busy  addr        len
    vecs[0] = '{2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0, 24'h000000, 8'd0};
    vecs[1] = '{2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b00, 8'h00, 2'b00, 1'b1, 24'h001000, 8'd3};
    vecs[2] = '{2'b00, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 2'b00, 2'b01, 8'hAA, 2'b00, 1'b1, 24'h000000, 8'd0};
    vecs[3] = '{2'b00, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 2'b00, 2'b01, 8'hBB, 2'b00, 1'b1, 24'h000000, 8'd0};
    vecs[4] = '{2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 2'b00, 1'b1, 24'h000000, 8'd0};
    vecs[5] = '{2'b00, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 2'b00, 2'b01, 8'hCC, 2'b00, 1'b1, 24'h000000, 8'd0};
    vecs[6] = '{2'b00, 1'b0, 1'b1, 8'hDD, 1'b0, 1'b0, 2'b00, 2'b01, 8'hDD, 2'b00, 1'b1, 24'h000000, 8'd0};
    vecs[7] = '{2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 2'b01, 1'b1, 24'h000000, 8'd0};
    vecs[8] = '{2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0, 24'h000000, 8'd0};
    vecs[9] = '{2'b00, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 2'b00, 1'b0, 24'h000000, 8'd0};

    for (int i = 0; i < 10; i++) begin
      bus.req_valid  = vecs[i].rv;
      bus.cmd_ready  = vecs[i].cr;
      bus.eng_rvalid = vecs[i].erv;
      bus.eng_rdata  = vecs[i].erd;
      bus.eng_done   = vecs[i].edn;
      #1;
      chk($sformatf("rd%0d_cmd_valid", i), 32'(bus.cmd_valid), 32'(vecs[i].e_cv));
      chk($sformatf("rd%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_rrdy));
      chk($sformatf("rd%0d_rvalid", i), 32'(bus.rvalid), 32'(vecs[i].e_rval));
      chk($sformatf("rd%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].e_rd));
      chk($sformatf("rd%0d_done", i), 32'(bus.done), 32'(vecs[i].e_dn));
      chk($sformatf("rd%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      chk($sformatf("rd%0d_cmd_addr", i), 32'(bus.cmd_addr), 32'(vecs[i].e_addr));
      chk($sformatf("rd%0d_cmd_len", i), 32'(bus.cmd_len), 32'(vecs[i].e_len));
      chk($sformatf("rd%0d_abort_err", i), {29'd0, bus.eng_abort, bus.err}, 0);
      chk($sformatf("rd%0d_owner", i), 32'(bus.owner), 0);
      step();
    end
    clear_inputs();

    // ---------------- round-robin, both requesters held valid
    do_reset();
    exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
    bus.req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_cmd("rr", found);
      exp_own = int'(exp_q.pop_front());
      chk($sformatf("rr%0d_owner", t), 32'(bus.owner), 32'(exp_own));
      chk($sformatf("rr%0d_ready_hold", t), 32'(bus.req_ready), 0);
      bus.cmd_ready = 1'b1;
      #1;
      chk($sformatf("rr%0d_req_ready", t), 32'(bus.req_ready), 32'(1) << exp_own);
      step();
      bus.cmd_ready = 1'b0;
      if (t == 3) bus.req_valid = 2'b00;
      bus.eng_done = 1'b1;
      #1;
      chk($sformatf("rr%0d_done", t), 32'(bus.done), 32'(1) << exp_own);
      chk($sformatf("rr%0d_req_ready_xfer", t), 32'(bus.req_ready), 0);
      step();
      bus.eng_done = 1'b0;
      #1;
      chk($sformatf("rr%0d_idle_gap", t), {30'd0, bus.busy, bus.cmd_valid}, 0);
    end
    step();

    // ---------------- requester 1 write with engine backpressure
    wb[0] = 8'h5A;
    wb[1] = 8'hA5;
    exp_q = {32'h5A, 32'hA5};
    bus.req_valid = 2'b10;
    wait_cmd("wr", found);
    chk("wr_owner", 32'(bus.owner), 1);
    chk("wr_cmd_write", 32'(bus.cmd_write), 1);
    chk("wr_cmd_len", 32'(bus.cmd_len), 1);
    chk("wr_cmd_addr", 32'(bus.cmd_addr), 32'h002000);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    bus.req_valid = 2'b00;
    bus.wvalid    = 2'b11;
    idx = 0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      bus.wdata      = {wb[idx], 8'hFF};
      bus.eng_wready = c[0];
      #1;
      chk($sformatf("wr%0d_eng_wvalid", c), 32'(bus.eng_wvalid), 1);
      chk($sformatf("wr%0d_eng_wdata", c), 32'(bus.eng_wdata), 32'(wb[idx]));
      chk($sformatf("wr%0d_wready", c), 32'(bus.wready), {30'd0, c[0], 1'b0});
      if (bus.eng_wvalid && bus.eng_wready) begin
        got = exp_q.pop_front();
        chk($sformatf("wr%0d_byte", c), 32'(bus.eng_wdata), got);
        idx++;
      end
      step();
    end
    chk("wr_bytes_moved", 32'(idx), 2);
    bus.wvalid     = 2'b00;
    bus.eng_wready = 1'b0;
    bus.eng_done   = 1'b1;
    #1;
    chk("wr_done", 32'(bus.done), 2);
    step();
    bus.eng_done = 1'b0;

    // ---------------- watchdog: command accepted, engine stalls
    bus.req_valid = 2'b01;
    wait_cmd("wd", found);
    chk("wd_owner", 32'(bus.owner), 0);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    bus.req_valid = 2'b00;
    for (int n = 1; n <= 8; n++) begin
      #1;
      chk($sformatf("wd_stall%0d", n), {29'd0, bus.busy, bus.eng_abort, bus.err[0]}, 32'b100);
      step();
    end
    #1;
    chk("wd_abort", 32'(bus.eng_abort), 1);
    chk("wd_err", 32'(bus.err), 1);
    chk("wd_abort_busy", 32'(bus.busy), 1);
    bus.req_valid = 2'b11;
    step();
    #1;
    chk("wd_after_idle", {29'd0, bus.busy, bus.eng_abort, bus.err[0]}, 0);
    step();
    #1;
    chk("wd_next_grant", {30'd0, bus.cmd_valid, bus.owner[0]}, 32'b11);

    // ---------------- tie: eng_done on the timeout cycle
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    bus.req_valid = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      #1;
      chk($sformatf("tie_stall%0d", n), 32'(bus.eng_abort), 0);
      step();
    end
    bus.eng_done = 1'b1;
    #1;
    chk("tie_done", 32'(bus.done), 2);
    chk("tie_no_err", {29'd0, bus.eng_abort, bus.err}, 0);
    step();
    bus.eng_done = 1'b0;
    #1;
    chk("tie_idle", {28'd0, bus.busy, bus.eng_abort, bus.err}, 0);
    step();
    #1;
    chk("tie_idle2", {28'd0, bus.busy, bus.eng_abort, bus.err}, 0);

    // ---------------- reset in the middle of a transfer
    bus.req_valid = 2'b01;
    wait_cmd("mr", found);
    chk("mr_owner", 32'(bus.owner), 0);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready  = 1'b0;
    bus.req_valid  = 2'b00;
    bus.eng_rvalid = 1'b1;
    bus.eng_rdata  = 8'h55;
    #1;
    chk("mr_in_xfer", 32'(bus.rvalid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid  = 2'b11;
    bus.wvalid     = 2'b11;
    bus.eng_wready = 1'b1;
    #1;
    chk_all_zero("mr");
    step();
    bus.wvalid     = 2'b00;
    bus.eng_rvalid = 1'b0;
    bus.eng_wready = 1'b0;
    #1;
    chk("mr_first_grant", {30'd0, bus.cmd_valid, bus.owner[0]}, 32'b10);
    clear_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
